// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path.
//  - rx_state_t   : receive FSM state encoding
//  - OVERSAMPLE   : oversample ticks per bit
//  - DVSR_W       : width of the baud divisor / baud counter
//  - parity_bad() : parity check helper
package uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int DVSR_W     = 11;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  // Mismatch between the data bits (given as their XOR), the received parity bit
  // and the selected sense: 1 means the frame's parity is wrong.
  function automatic logic parity_bad(input logic data_xor, input logic pbit, input logic odd);
    return data_xor ^ pbit ^ odd;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Free-running oversample tick generator, shared by the receive and transmit sides.
// Ports:
//  clk   in  1  system clock
//  reset in  1  asynchronous active-high reset
//  dvsr  in  W  divisor; tick period = dvsr + 1 clocks
//  tick  out 1  high for the single cycle in which the counter equals dvsr
// A new dvsr is picked up at the next compare without restarting the counter;
// if the counter is already past the new value it runs to the top and wraps.
module uart_baud_gen #(
  parameter int W = uart_pkg::DVSR_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] dvsr,
  output logic         tick
);

  logic [W-1:0] count_r;

  // Divisor counter: 0..dvsr then back to 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r <= '0;
    end else if (count_r == dvsr) begin
      count_r <= '0;
    end else begin
      count_r <= count_r + 1'b1;
    end
  end

  assign tick = (count_r == dvsr);

endmodule

// File: rtl/uart_rx_core.sv
// UART serial receiver: input synchroniser, 16x oversampled start/data/parity/stop
// FSM and registered result outputs feeding the rx FIFO.
// Ports:
//  clk          in  1     system clock
//  reset        in  1     asynchronous active-high reset
//  dvsr         in  11    baud divisor, tick rate = clk/(dvsr+1) = 16 x baud
//  rx           in  1     serial line, asynchronous, idle high
//  dout         out DBIT  last received byte, held until the next frame completes
//  rx_done_tick out 1     one-cycle pulse when a frame completes
//  frame_err    out 1     stop bit was sampled low on the completed frame
//  parity_err   out 1     parity mismatch on the completed frame
//  rx_busy      out 1     receiver is inside a frame
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int DBIT       = 8,
  parameter int SB_TICK    = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DVSR_W-1:0] dvsr,
  input  logic              rx,
  output logic [DBIT-1:0]   dout,
  output logic              rx_done_tick,
  output logic              frame_err,
  output logic              parity_err,
  output logic              rx_busy
);

  localparam logic [4:0] MID_START = 5'(OVERSAMPLE / 2 - 1);
  localparam logic [4:0] BIT_LAST  = 5'(OVERSAMPLE - 1);
  localparam logic [4:0] STOP_LAST = 5'(SB_TICK - 1);
  localparam logic [2:0] N_LAST    = 3'(DBIT - 1);
  localparam logic       PAR_ON    = (PARITY_EN != 0);
  localparam logic       PAR_ODD   = (PARITY_ODD != 0);

  logic            tick_s;
  logic [1:0]      sync_r;
  logic            rx_s;
  rx_state_t       state_r;
  logic [4:0]      s_r;
  logic [2:0]      n_r;
  logic [DBIT-1:0] b_r;
  logic            p_r;

  uart_baud_gen #(.W(DVSR_W)) u_baud (
    .clk   (clk),
    .reset (reset),
    .dvsr  (dvsr),
    .tick  (tick_s)
  );

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_r <= 2'b11;
    end else begin
      sync_r <= {sync_r[0], rx};
    end
  end

  assign rx_s = sync_r[1];

  // Receive FSM with its counters, shift register and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      s_r          <= 5'd0;
      n_r          <= 3'd0;
      b_r          <= '0;
      p_r          <= 1'b0;
      dout         <= '0;
      rx_done_tick <= 1'b0;
      frame_err    <= 1'b0;
      parity_err   <= 1'b0;
      rx_busy      <= 1'b0;
    end else begin
      rx_done_tick <= 1'b0;
      case (state_r)
        IDLE: begin
          // Only state that reacts without a tick, so a start edge is never missed.
          if (!rx_s) begin
            state_r <= START;
            s_r     <= 5'd0;
            rx_busy <= 1'b1;
          end
        end
        START: begin
          if (tick_s) begin
            if (s_r == MID_START) begin
              // Line back high at mid start bit: treat as a glitch and drop silently.
              if (!rx_s) begin
                state_r <= DATA;
                s_r     <= 5'd0;
                n_r     <= 3'd0;
              end else begin
                state_r <= IDLE;
                rx_busy <= 1'b0;
              end
            end else begin
              s_r <= s_r + 5'd1;
            end
          end
        end
        DATA: begin
          if (tick_s) begin
            if (s_r == BIT_LAST) begin
              b_r <= {rx_s, b_r[DBIT-1:1]};
              s_r <= 5'd0;
              if (n_r == N_LAST) begin
                state_r <= PAR_ON ? PARITY : STOP;
              end else begin
                n_r <= n_r + 3'd1;
              end
            end else begin
              s_r <= s_r + 5'd1;
            end
          end
        end
        PARITY: begin
          if (tick_s) begin
            if (s_r == BIT_LAST) begin
              p_r     <= rx_s;
              s_r     <= 5'd0;
              state_r <= STOP;
            end else begin
              s_r <= s_r + 5'd1;
            end
          end
        end
        STOP: begin
          if (tick_s) begin
            if (s_r == STOP_LAST) begin
              state_r      <= IDLE;
              rx_busy      <= 1'b0;
              rx_done_tick <= 1'b1;
              dout         <= b_r;
              frame_err    <= ~rx_s;
              parity_err   <= PAR_ON & parity_bad(^b_r, p_r, PAR_ODD);
            end else begin
              s_r <= s_r + 5'd1;
            end
          end
        end
        default: begin
          state_r <= IDLE;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
`timescale 1ns/1ps
// Self-checking bench for uart_rx_core: an 8N1 receiver and an 8O1 receiver on
// separate serial lines, compared every cycle against a frame-level model.
module tb_uart_rx_core;

  logic        clk;
  logic        reset;
  logic [10:0] dvsr;
  logic        rx_a, rx_b;
  logic [7:0]  dout_a, dout_b;
  logic        done_a, done_b, fe_a, fe_b, pe_a, pe_b, busy_a, busy_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  uart_rx_core #(.DBIT(8), .SB_TICK(16), .PARITY_EN(0), .PARITY_ODD(0)) dut (
    .clk(clk), .reset(reset), .dvsr(dvsr), .rx(rx_a),
    .dout(dout_a), .rx_done_tick(done_a), .frame_err(fe_a),
    .parity_err(pe_a), .rx_busy(busy_a)
  );

  uart_rx_core #(.DBIT(8), .SB_TICK(16), .PARITY_EN(1), .PARITY_ODD(1)) dut_par (
    .clk(clk), .reset(reset), .dvsr(dvsr), .rx(rx_b),
    .dout(dout_b), .rx_done_tick(done_b), .frame_err(fe_b),
    .parity_err(pe_b), .rx_busy(busy_b)
  );

  // One expected frame result, registered when the start edge is driven.
  typedef struct {
    logic [7:0] data;
    logic       fe;
    logic       pe;
    int         edge_cyc;
    int         ticks;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  logic [7:0] held_dout [2];
  logic       held_fe   [2];
  logic       held_pe   [2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check1(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model side of one receiver: pulses consume the queue, outputs must match held values.
  task automatic compare_side(input int side, input logic done, input logic [7:0] d,
                              input logic fe, input logic pe);
    exp_t  e;
    int    span, lo, hi, dt;
    bit    empty;
    string tag;
    tag = (side == 0) ? "a" : "b";
    if (done) begin
      empty = (side == 0) ? (qa.size() == 0) : (qb.size() == 0);
      vectors++;
      if (empty) begin
        miscompares++;
        $display("FAIL spurious_pulse_%s: got pulse, expected none (t=%0t)", tag, $time);
      end else begin
        if (side == 0) e = qa.pop_front();
        else           e = qb.pop_front();
        held_dout[side] = e.data;
        held_fe[side]   = e.fe;
        held_pe[side]   = e.pe;
        // Frame is sampled mid-stop: ticks counted from the first tick after the
        // synchronised edge is seen (3 cycles), tick phase anywhere in one period.
        span = int'(dvsr) + 1;
        lo   = 4 + (e.ticks - 1) * span;
        hi   = 3 + e.ticks * span;
        dt   = cyc - e.edge_cyc;
        if (dt < lo || dt > hi) begin
          miscompares++;
          $display("FAIL latency_%s: got %0d cycles, expected %0d..%0d", tag, dt, lo, hi);
        end
      end
    end
    check1({"dout_", tag}, 32'(d), 32'(held_dout[side]));
    check1({"frame_err_", tag}, 32'(fe), 32'(held_fe[side]));
    check1({"parity_err_", tag}, 32'(pe), 32'(held_pe[side]));
  endtask

  // Per-cycle comparison against the model, sampled on the inactive edge.
  always @(negedge clk) begin
    if (reset) begin
      for (int k = 0; k < 2; k++) begin
        held_dout[k] = 8'h00;
        held_fe[k]   = 1'b0;
        held_pe[k]   = 1'b0;
      end
      check1("reset_done_a", 32'(done_a), 32'd0);
      check1("reset_done_b", 32'(done_b), 32'd0);
      check1("reset_dout_a", 32'(dout_a), 32'd0);
      check1("reset_busy_b", 32'(busy_b), 32'd0);
    end else begin
      compare_side(0, done_a, dout_a, fe_a, pe_a);
      compare_side(1, done_b, dout_b, fe_b, pe_b);
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_line(input int side, input logic v);
    if (side == 0) rx_a = v;
    else           rx_b = v;
  endtask

  // Drive one frame; a bad stop bit is low for 3/4 of the bit then returns high.
  task automatic send_frame(input int side, input logic [7:0] data, input logic pbit,
                            input logic stop_ok, input int bit_clk, input logic expect_pulse);
    exp_t e;
    int   ones;
    @(posedge clk);
    #1;
    ones       = $countones(data) + int'(pbit);
    e.data     = data;
    e.fe       = ~stop_ok;
    e.pe       = (side == 1) ? ((ones % 2) == 0) : 1'b0;
    e.edge_cyc = cyc;
    e.ticks    = (side == 1) ? (8 + 16 * 9 + 16) : (8 + 16 * 8 + 16);
    if (expect_pulse) begin
      if (side == 0) qa.push_back(e);
      else           qb.push_back(e);
    end
    set_line(side, 1'b0);
    wait_clks(bit_clk - 1);
    for (int i = 0; i < 8; i++) begin
      set_line(side, data[i]);
      wait_clks(bit_clk);
    end
    if (side == 1) begin
      set_line(side, pbit);
      wait_clks(bit_clk);
    end
    if (stop_ok) begin
      set_line(side, 1'b1);
      wait_clks(bit_clk);
    end else begin
      set_line(side, 1'b0);
      wait_clks((3 * bit_clk) / 4);
      set_line(side, 1'b1);
      wait_clks(bit_clk / 4);
    end
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((qa.size() != 0 || qb.size() != 0) && t < 20000) begin
      @(posedge clk);
      t++;
    end
    #1;
    vectors++;
    if (qa.size() != 0 || qb.size() != 0) begin
      miscompares++;
      $display("FAIL drain_timeout: got %0d/%0d pending, expected 0", qa.size(), qb.size());
      qa.delete();
      qb.delete();
    end
  endtask

  // Hard stop in case the stimulus itself stalls.
  initial begin
    #3ms;
    $display("FAIL watchdog: got no completion, expected finish before 3 ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] rd;
    int         side;
    reset = 1'b1;
    rx_a  = 1'b1;
    rx_b  = 1'b1;
    dvsr  = 11'd3;
    wait_clks(4);
    check1("rst_fe_a", 32'(fe_a), 32'd0);
    check1("rst_pe_b", 32'(pe_b), 32'd0);
    reset = 1'b0;
    wait_clks(4);
    check1("idle_busy_a", 32'(busy_a), 32'd0);
    check1("idle_dout_b", 32'(dout_b), 32'd0);

    // Good 8N1 byte, then two quiet frame times.
    send_frame(0, 8'hA5, 1'b0, 1'b1, 64, 1'b1);
    check1("lit_a5_dout", 32'(dout_a), 32'hA5);
    check1("lit_a5_fe", 32'(fe_a), 32'd0);
    wait_clks(1280);

    // Short low glitch on an idle line: busy rises, then falls at mid start bit.
    set_line(0, 1'b0);
    wait_clks(2);
    set_line(0, 1'b1);
    wait_clks(4);
    check1("glitch_busy_hi", 32'(busy_a), 32'd1);
    wait_clks(60);
    check1("glitch_busy_lo", 32'(busy_a), 32'd0);

    // Stop bit forced low, then a good byte clears the flag.
    send_frame(0, 8'h3C, 1'b0, 1'b0, 64, 1'b1);
    check1("lit_3c_dout", 32'(dout_a), 32'h3C);
    check1("lit_3c_fe", 32'(fe_a), 32'd1);
    wait_clks(64);
    send_frame(0, 8'h01, 1'b0, 1'b1, 64, 1'b1);
    check1("lit_01_fe", 32'(fe_a), 32'd0);
    wait_clks(64);

    // Odd parity: 0x07 has three ones, so parity bit 0 is correct.
    send_frame(1, 8'h07, 1'b0, 1'b1, 64, 1'b1);
    check1("lit_par_ok", 32'(pe_b), 32'd0);
    wait_clks(64);
    send_frame(1, 8'h07, 1'b1, 1'b1, 64, 1'b1);
    check1("lit_par_bad", 32'(pe_b), 32'd1);
    wait_clks(64);

    // Reset during data bit 4 of 0xF0 (remaining bits high), then a good 0x5A.
    fork
      send_frame(0, 8'hF0, 1'b0, 1'b1, 64, 1'b0);
      begin
        wait_clks(64 * 5 + 20);
        reset = 1'b1;
        wait_clks(3);
        reset = 1'b0;
      end
    join
    check1("post_rst_dout", 32'(dout_a), 32'd0);
    check1("post_rst_busy", 32'(busy_a), 32'd0);
    wait_clks(64);
    send_frame(0, 8'h5A, 1'b0, 1'b1, 64, 1'b1);
    check1("lit_5a_dout", 32'(dout_a), 32'h5A);
    wait_clks(64);

    // Random frames at dvsr = 3.
    for (int i = 0; i < 12; i++) begin
      rd   = 8'($urandom_range(0, 255));
      side = int'($urandom_range(0, 1));
      send_frame(side, rd, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), 64, 1'b1);
      wait_clks(int'($urandom_range(64, 200)));
    end
    wait_drain();

    // Fastest divisor: a tick every clock.
    dvsr = 11'd0;
    wait_clks(2100);
    for (int i = 0; i < 8; i++) begin
      rd   = 8'($urandom_range(0, 255));
      side = int'($urandom_range(0, 1));
      send_frame(side, rd, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), 16, 1'b1);
      wait_clks(int'($urandom_range(16, 50)));
    end
    wait_drain();

    // Back-to-back frames with the transmitter 2% slow / 2% fast (nominal 800 clk/bit).
    dvsr = 11'd49;
    wait_clks(2100);
    send_frame(0, 8'h00, 1'b0, 1'b1, 816, 1'b1);
    send_frame(0, 8'hFF, 1'b0, 1'b1, 784, 1'b1);
    send_frame(0, 8'h55, 1'b0, 1'b1, 816, 1'b1);
    check1("lit_55_dout", 32'(dout_a), 32'h55);
    wait_drain();

    wait_clks(200);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
